laser_vga_arbiter: RTL and testbench

Shares the single VGA pixel-write port among several tower laser datapaths. Each laser datapath draws and erases its beam one pixel per cycle, and only one of them may drive the VGA adapter at a time. This block grants the port to one requester at a time in round-robin order, caps the length of each tenure, and registers the winning pixel onto the VGA adapter inputs. It sits between the per-tower laser datapaths and the top-level VGA adapter.

---
 rtl/laser_vga_arbiter.sv | 147 ++++++++++++++
 tb/tb_laser_vga_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_vga_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// laser_vga_arbiter
//
// Shares the single VGA pixel-write port among N_REQ tower laser datapaths.
// One requester owns the port at a time. Ownership is handed out in
// round-robin order, starting with the index after the most recent owner.
// A tenure ends when the owner drops req or when it has had MAX_BURST pixels
// accepted. Every hand-over passes through exactly one IDLE cycle. The
// winning pixel is registered onto the VGA adapter inputs one cycle after it
// is accepted.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   req         req[i]: requester i presents a valid pixel this cycle
//   req_coords  slice i = {x[7:0], y[6:0]} of requester i's pixel
//   req_colour  slice i = 9-bit colour of requester i's pixel
//   grant       one-hot (or zero) grant, registered
//   owner       index of the current or most recent owner
//   busy        high while a tenure is in progress (SERVE state)
//   vga_x       registered pixel x
//   vga_y       registered pixel y
//   vga_colour  registered pixel colour
//   vga_plot    write enable for the VGA adapter, one cycle per pixel
// -----------------------------------------------------------------------------
module laser_vga_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req,
  input  logic [15*N_REQ-1:0]        req_coords,
  input  logic [9*N_REQ-1:0]         req_colour,
  output logic [N_REQ-1:0]           grant,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       busy,
  output logic [7:0]                 vga_x,
  output logic [6:0]                 vga_y,
  output logic [8:0]                 vga_colour,
  output logic                       vga_plot
);

  localparam int OW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  localparam logic [BW-1:0]    BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [N_REQ-1:0] GRANT_ONE  = {{(N_REQ-1){1'b0}}, 1'b1};

  localparam logic IDLE  = 1'b0;
  localparam logic SERVE = 1'b1;

  logic          state;
  logic [BW-1:0] burst_cnt;
  logic [OW-1:0] next_owner;
  logic          accept;
  logic [14:0]   sel_coords;
  logic [8:0]    sel_colour;

  // In SERVE the grant register is exactly one-hot(owner), so an accept is
  // simply the owner's request while serving.
  assign accept = (state == SERVE) & req[owner];
  assign busy   = (state == SERVE);

  // Round-robin search: first asserted request at owner+1, owner+2, ...
  // wrapping modulo N_REQ. The owner itself is examined last, which lets a
  // lone requester win again after its IDLE cycle.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    next_owner = owner;
    for (int k = N_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(owner) + k) % N_REQ;
      if (req[idx]) next_owner = OW'(idx);
    end
  end

  // Owner's pixel, selected by a plain mux so no multiplied index is needed.
  always_comb begin
    sel_coords = '0;
    sel_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == OW'(i)) begin
        sel_coords = req_coords[15*i +: 15];
        sel_colour = req_colour[9*i +: 9];
      end
    end
  end

  // Arbitration state machine.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      owner     <= OW'(N_REQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= next_owner;
            grant     <= GRANT_ONE << next_owner;
            burst_cnt <= '0;
            state     <= SERVE;
          end
        end
        default: begin
          if (accept) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (burst_cnt == BURST_LAST) begin
              state <= IDLE;
              grant <= '0;
            end
          end else begin
            // Owner stalled or finished its beam: release the port.
            state <= IDLE;
            grant <= '0;
          end
        end
      endcase
    end
  end

  // Pixel output register: loads only on an accepted edge, holds otherwise.
  // NOTE: these datapath registers are reset because the adapter must see
  // a defined pixel and no write strobe while the arbiter is held in reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= accept;
      if (accept) begin
        vga_x      <= sel_coords[14:7];
        vga_y      <= sel_coords[6:0];
        vga_colour <= sel_colour;
      end
    end
  end

endmodule

// File: tb/tb_laser_vga_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_laser_vga_arbiter
//
// Requester behaviour: each laser datapath is a queue of pixels. It raises
// req while its queue front is a pixel and advances only after an accepted
// edge. A "bubble" entry drops req for exactly one edge (models a stall or
// the end of a beam followed by re-raising req).
// Expected plots {owner, x, y, colour} are pushed into a scoreboard in the
// hand-derived arbitration order; a monitor pops one entry per vga_plot.
// -----------------------------------------------------------------------------
module tb_laser_vga_arbiter;

  localparam int N = 4;
  localparam logic [24:0] BUBBLE = 25'h1000000;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [15*N-1:0]  req_coords;
  logic [9*N-1:0]   req_colour;
  logic [N-1:0]     grant;
  logic [1:0]       owner;
  logic             busy;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [8:0]       vga_colour;
  logic             vga_plot;

  laser_vga_arbiter #(.N_REQ(N), .MAX_BURST(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_coords (req_coords),
    .req_colour (req_colour),
    .grant      (grant),
    .owner      (owner),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  // Stimulus queues: {bubble, x[7:0], y[6:0], colour[8:0]}
  logic [24:0] pq [N][$];
  // Scoreboard: {owner[1:0], x[7:0], y[6:0], colour[8:0]}
  logic [25:0] sb [$];

  int n_cmp = 0;
  int n_bad = 0;

  logic [N-1:0] acc;

  logic [3:0] run_val [40];
  int         run_len [40];
  int         n_runs;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic add_px(input int r, input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
    pq[r].push_back({1'b0, x, y, c});
  endtask

  task automatic add_bubble(input int r);
    pq[r].push_back(BUBBLE);
  endtask

  task automatic expect_px(input int r, input logic [7:0] x, input logic [6:0] y, input logic [8:0] c);
    sb.push_back({2'(r), x, y, c});
  endtask

  // Present each requester's queue front on the DUT inputs.
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (pq[i].size() > 0 && !pq[i][0][24]) begin
        req[i]                = 1'b1;
        req_coords[15*i +: 15] = pq[i][0][23:9];
        req_colour[9*i +: 9]   = pq[i][0][8:0];
      end else begin
        req[i] = 1'b0;
      end
    end
  endtask

  task automatic flush_all();
    for (int i = 0; i < N; i++) pq[i].delete();
    drive();
  endtask

  // Record consecutive runs of identical grant values, one sample per cycle.
  task automatic record_runs(input int nsteps);
    n_runs = 0;
    for (int s = 0; s < nsteps; s++) begin
      step();
      if (n_runs > 0 && run_val[n_runs-1] == grant) begin
        run_len[n_runs-1]++;
      end else if (n_runs < 40) begin
        run_val[n_runs] = grant;
        run_len[n_runs] = 1;
        n_runs++;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_owner", 32'(owner), 32'd3);
  endtask

  // Requester processes: pop on accepted edges (or after a bubble edge).
  initial begin
    forever begin
      @(negedge clk);
      acc = grant & req;
      @(posedge clk);
      #1;
      if (!reset) begin
        for (int i = 0; i < N; i++) begin
          if (pq[i].size() > 0 && (pq[i][0][24] || acc[i]))
            void'(pq[i].pop_front());
        end
      end
      drive();
    end
  end

  // Monitor: every plot must match the next scoreboard entry.
  initial begin
    logic [25:0] exp_e;
    forever begin
      @(negedge clk);
      if (vga_plot === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL plot_unexpected: got owner=%0d x=%0d y=%0d colour=0x%0h, expected no plot (t=%0t)",
                   owner, vga_x, vga_y, vga_colour, $time);
        end else begin
          exp_e = sb.pop_front();
          check("plot", 32'({owner, vga_x, vga_y, vga_colour}), 32'(exp_e));
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 50000ns");
    $fatal(1);
  end

  initial begin
    logic [3:0] rr_val [9];
    int         rr_len [8];
    rr_val = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    rr_len = '{4, 1, 4, 1, 4, 1, 4, 1};

    reset      = 1'b1;
    req        = '0;
    req_coords = '0;
    req_colour = '0;
    repeat (3) step();

    // ---------------- reset state ----------------
    check("rst_grant",  32'(grant),      32'h0);
    check("rst_owner0", 32'(owner),      32'd3);
    check("rst_busy",   32'(busy),       32'h0);
    check("rst_plot",   32'(vga_plot),   32'h0);
    check("rst_xyc",    32'({vga_x, vga_y, vga_colour}), 32'h0);

    // ---------------- reset with req=1111 ----------------
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      add_px(i, 8'(10 + i), 7'(1 + i), 9'(16 + i));
      add_px(i, 8'(20 + i), 7'(1 + i), 9'(16 + i));
    end
    expect_px(0, 8'd10, 7'd1, 9'h010);
    drive();
    step();                                   // grant to requester 0
    check("t1_grant_r0", 32'(grant), 32'h1);
    step();                                   // first pixel accepted
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t1_async_grant", 32'(grant),    32'h0);
    check("t1_async_plot",  32'(vga_plot), 32'h0);
    check("t1_async_busy",  32'(busy),     32'h0);
    check("t1_async_xyc",   32'({vga_x, vga_y, vga_colour}), 32'h0);
    step();
    flush_all();
    step();
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      check("t1_idle_grant", 32'(grant), 32'h0);
    end

    // ---------------- single beam, requester 2 ----------------
    for (int k = 0; k < 21; k++) begin
      add_px(2, 8'(50 + k), 7'd30, 9'h007);
      expect_px(2, 8'(50 + k), 7'd30, 9'h007);
    end
    drive();
    step();
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_owner", 32'(owner), 32'd2);
    check("t2_busy",  32'(busy),  32'h1);
    begin
      int t;
      t = 0;
      while (pq[2].size() > 0 && t < 60) begin
        step();
        t++;
      end
      check("t2_drain_in_budget", 32'(t < 60), 32'h1);
    end
    check("t2_grant_hold", 32'(grant), 32'h4);
    step();
    check("t2_grant_drop", 32'(grant), 32'h0);
    check("t2_busy_drop",  32'(busy),  32'h0);
    repeat (2) step();

    // ---------------- round robin ----------------
    do_reset();
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < 3; k++) add_px(r, 8'(16*r + k), 7'(40 + r), 9'(r));
      add_bubble(r);
      for (int k = 3; k < 6; k++) add_px(r, 8'(16*r + k), 7'(40 + r), 9'(r));
    end
    for (int rnd = 0; rnd < 2; rnd++)
      for (int r = 0; r < N; r++)
        for (int k = 3*rnd; k < 3*rnd + 3; k++)
          expect_px(r, 8'(16*r + k), 7'(40 + r), 9'(r));
    drive();
    record_runs(45);
    for (int j = 0; j < 9; j++) check("t3_rr_grant_seq", 32'(run_val[j]), 32'(rr_val[j]));
    for (int j = 0; j < 8; j++) check("t3_rr_run_len",   32'(run_len[j]), 32'(rr_len[j]));

    // ---------------- burst cap ----------------
    do_reset();
    for (int k = 0; k < 40; k++) add_px(0, 8'(100 + k), 7'd5, 9'(k));
    for (int k = 0; k < 3; k++)  add_px(1, 8'(200 + k), 7'd6, 9'h1F0);
    for (int k = 0; k < 24; k++) expect_px(0, 8'(100 + k), 7'd5, 9'(k));
    for (int k = 0; k < 3; k++)  expect_px(1, 8'(200 + k), 7'd6, 9'h1F0);
    for (int k = 24; k < 40; k++) expect_px(0, 8'(100 + k), 7'd5, 9'(k));
    drive();
    record_runs(55);
    check("t4_cap_val0", 32'(run_val[0]), 32'h1);
    check("t4_cap_len0", 32'(run_len[0]), 32'd24);
    check("t4_cap_val1", 32'(run_val[1]), 32'h0);
    check("t4_cap_len1", 32'(run_len[1]), 32'd1);
    check("t4_cap_val2", 32'(run_val[2]), 32'h2);
    check("t4_cap_len2", 32'(run_len[2]), 32'd4);
    check("t4_cap_val4", 32'(run_val[4]), 32'h1);
    check("t4_cap_len4", 32'(run_len[4]), 32'd17);

    // ---------------- stall of owner 3 ----------------
    do_reset();
    for (int k = 1; k <= 5; k++) add_px(3, 8'(k), 7'd100, 9'h1AA);
    add_bubble(3);
    for (int k = 6; k <= 10; k++) add_px(3, 8'(k), 7'd100, 9'h1AA);
    for (int k = 1; k <= 10; k++) expect_px(3, 8'(k), 7'd100, 9'h1AA);
    drive();
    record_runs(20);
    check("t5_stall_val0", 32'(run_val[0]), 32'h8);
    check("t5_stall_len0", 32'(run_len[0]), 32'd6);
    check("t5_stall_val1", 32'(run_val[1]), 32'h0);
    check("t5_stall_len1", 32'(run_len[1]), 32'd1);
    check("t5_stall_val2", 32'(run_val[2]), 32'h8);
    check("t5_stall_len2", 32'(run_len[2]), 32'd6);
    check("t5_stall_val3", 32'(run_val[3]), 32'h0);

    // ---------------- reset mid-tenure ----------------
    do_reset();
    for (int k = 0; k < 15; k++) add_px(1, 8'(60 + k), 7'd70, 9'h0F0);
    for (int k = 0; k < 9; k++)  expect_px(1, 8'(60 + k), 7'd70, 9'h0F0);
    drive();
    step();
    check("t6_grant_r1", 32'(grant), 32'h2);
    repeat (9) step();                        // 9 accepted, 10th presented
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_plot",  32'(vga_plot), 32'h0);
    check("t6_async_grant", 32'(grant),    32'h0);
    step();
    pq[1].delete();
    add_px(1, 8'd60, 7'd70, 9'h0F0);
    add_px(1, 8'd61, 7'd70, 9'h0F0);
    expect_px(1, 8'd60, 7'd70, 9'h0F0);
    expect_px(1, 8'd61, 7'd70, 9'h0F0);
    drive();
    reset = 1'b0;
    step();
    check("t6_regrant",  32'(grant), 32'h2);
    check("t6_owner",    32'(owner), 32'd1);
    repeat (6) step();
    check("t6_idle_end", 32'(grant), 32'h0);

    // ---------------- all expected plots seen ----------------
    repeat (3) step();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
